fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Fetch-stage program-counter unit for the pipelined MIPS core. Holds the architectural fetch PC and selects the next PC.
- Next-PC sources: sequential, branch/jump redirect, exception vector, or ERET return.
- A branch that arrives while fetch is stalled is captured in a one-entry pending-redirect buffer, so no redirect is lost.
- Flags fetch-address errors (AdEL) for the CP0 exception logic.

Parameters:
- ADDR_W, 32, width of PC and all address ports.
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000, legal fetch window size in bytes.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- stall_i  input  1  hazard stall; PC holds when 1 (unless flushed)
- br_take_i  input  1  branch/jump taken, resolved in ID
- br_target_i  input  ADDR_W  branch/jump target
- exc_req_i  input  1  exception accepted by CP0; redirect to EXC_VEC
- eret_i  input  1  ERET committed; redirect to epc_i
- epc_i  input  ADDR_W  exception return address from CP0
- pc_o  output  ADDR_W  current fetch PC (registered)
- npc_o  output  ADDR_W  next PC (combinational, same selection as the register update)
- redir_pend_o  output  1  pending-redirect buffer valid
- fetch_adel_o  output  1  current PC misaligned or outside the fetch window

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset state: pc_o=RESET_PC, pending valid=0, pending target=0. Reset overrides every other input in the same edge. A reset asserted mid-stall or with a redirect pending discards the pending entry.
- Update priority at each posedge, highest first:
  - exc_req_i: PC<=EXC_VEC; pending cleared.
  - eret_i: PC<=epc_i; pending cleared.
  - stall_i=1 and br_take_i=1: PC holds; pending<=br_target_i, valid=1. A newer target overwrites an older one.
  - stall_i=1 only: PC and pending both hold.
  - br_take_i=1: PC<=br_target_i; pending cleared. A new branch beats an older pending entry.
  - pending valid: PC<=pending target; pending cleared.
  - Otherwise: PC<=PC+4.
- Flush versus stall: exc_req_i and eret_i take effect even when stall_i=1. If both are asserted, exc_req_i wins.
- Next-PC output: npc_o is the value PC would load on the coming edge. When PC holds, npc_o=pc_o. Reset is not reflected in npc_o.
- Arithmetic: PC+4 uses ADDR_W-bit unsigned arithmetic and wraps modulo 2^ADDR_W; no saturation.
- Address check: fetch_adel_o = (pc_o[1:0]!=0) | (pc_o<IMEM_BASE) | (pc_o>=IMEM_BASE+IMEM_SIZE).
  - Combinational from pc_o; no latency.
  - The window bound is computed at ADDR_W+1 bits so it cannot wrap.
  - The block does not suppress fetch on error; CP0 decides.
- Latency:
  - A redirect applied while not stalled is visible on pc_o one cycle later.
  - A buffered redirect is visible one cycle after stall_i falls.
- Status output: redir_pend_o is the registered pending-valid bit.

Decomposition:
- Package pc_pkg holds:
  - Default constants RESET_PC, EXC_VEC, IMEM_BASE, IMEM_SIZE.
  - Enum npc_sel_e {SEL_HOLD, SEL_SEQ, SEL_BR, SEL_PEND, SEL_EXC, SEL_ERET}, used by both RTL and the bench's scoreboard model.
- One sub-module, pc_redirect_buf: one-entry pending-target register with set/overwrite/clear controls.
- Priority select, PC register and address check stay in the top.

Test Plan:
- Reset then 4 unstalled cycles -> pc_o = 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; fetch_adel_o=0.
- At PC=0x3010, stall_i=1 for 3 cycles with br_take_i=1, target 0x3100, in the first stall cycle -> pc_o stays 0x3010 and redir_pend_o=1 for the stall cycles. First edge after stall_i falls: pc_o=0x3100, redir_pend_o=0.
- Two branches while stalled (0x3100 then 0x3200), then unstall -> pc_o=0x3200. With pending=0x3200, unstall together with br_take_i (target 0x3300) -> pc_o=0x3300.
- stall_i=1, exc_req_i=1 and eret_i=1 in the same cycle, pending valid -> pc_o=0x4180, redir_pend_o=0. Next cycle eret_i=1, epc_i=0x3008 -> pc_o=0x3008.
- Branch target 0x3002 -> fetch_adel_o=1. Target 0x2FFC -> 1. Target 0x6FFC -> 0. Target 0x7000 -> 1.
- With ADDR_W=32, branch to 0xFFFF_FFFC then one sequential step -> pc_o=0x0000_0000 (wrap); fetch_adel_o=1. Reset asserted mid-stall with a pending redirect -> pc_o=0x3000, redir_pend_o=0 next cycle.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage PC unit: the default address map and
// the next-PC source selector used by the datapath and by its models.
package pc_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] IMEM_SIZE = 32'h0000_4000;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_PEND,
    SEL_EXC,
    SEL_ERET
  } npc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer: holds a branch target that arrived while
// fetch was stalled until the PC is free to take it.
module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-1:0] set_target,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block ordering.
    if (reset) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (set) begin
      valid  <= 1'b1;
      target <= set_target;
    end else if (clr) begin
      valid  <= 1'b0;
    end
  end

  // The controller only buffers while holding and only clears while moving.
  assert property (@(posedge clk) disable iff (reset) !(set && clr));

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with prioritised next-PC selection, a pending-redirect
// buffer for branches resolved during stalls, and fetch address-error flagging.
module fetch_pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(pc_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(pc_pkg::EXC_VEC),
  parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(pc_pkg::IMEM_BASE),
  parameter logic [ADDR_W-1:0] IMEM_SIZE = ADDR_W'(pc_pkg::IMEM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              br_take_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              exc_req_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] npc_o,
  output logic              redir_pend_o,
  output logic              fetch_adel_o
);

  npc_sel_e          sel;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] pc_seq;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic              buf_set;
  logic              buf_clr;

  // Flushes outrank stalls; a fresh branch outranks an older buffered one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel = SEL_SEQ;
    if (exc_req_i)        sel = SEL_EXC;
    else if (eret_i)      sel = SEL_ERET;
    else if (stall_i)     sel = SEL_HOLD;
    else if (br_take_i)   sel = SEL_BR;
    else if (pend_valid)  sel = SEL_PEND;
  end

  assign pc_seq = pc_q + ADDR_W'(4);

  always_comb begin
    npc = pc_seq;
    case (sel)
      SEL_HOLD: npc = pc_q;
      SEL_SEQ:  npc = pc_seq;
      SEL_BR:   npc = br_target_i;
      SEL_PEND: npc = pend_target;
      SEL_EXC:  npc = EXC_VEC;
      SEL_ERET: npc = epc_i;
      default:  npc = pc_seq;
    endcase
  end

  // Buffer only while holding; any movement of the PC consumes or kills it.
  assign buf_set = (sel == SEL_HOLD) && br_take_i;
  assign buf_clr = (sel != SEL_HOLD);

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .set        (buf_set),
    .clr        (buf_clr),
    .set_target (br_target_i),
    .valid      (pend_valid),
    .target     (pend_target)
  );

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= npc;
  end

  // Window limit is one bit wider so a window ending at the top of the
  // address space cannot wrap to zero.
  logic [ADDR_W:0] pc_ext;
  logic [ADDR_W:0] lo_ext;
  logic [ADDR_W:0] hi_ext;

  assign pc_ext = {1'b0, pc_q};
  assign lo_ext = {1'b0, IMEM_BASE};
  assign hi_ext = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};

  assign fetch_adel_o = (pc_q[1:0] != 2'b00) || (pc_ext < lo_ext) || (pc_ext >= hi_ext);

  assign pc_o         = pc_q;
  assign npc_o        = npc;
  assign redir_pend_o = pend_valid;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_fetch_pc_ctrl;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        br_take_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        exc_req_i = 1'b0;
  logic        eret_i = 1'b0;
  logic [31:0] epc_i = '0;
  logic [31:0] pc_o;
  logic [31:0] npc_o;
  logic        redir_pend_o;
  logic        fetch_adel_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .br_take_i    (br_take_i),
    .br_target_i  (br_target_i),
    .exc_req_i    (exc_req_i),
    .eret_i       (eret_i),
    .epc_i        (epc_i),
    .pc_o         (pc_o),
    .npc_o        (npc_o),
    .redir_pend_o (redir_pend_o),
    .fetch_adel_o (fetch_adel_o)
  );

  always #5 clk = ~clk;

  // Reference model state: architectural PC plus a queue holding at most one
  // buffered redirect target.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_adel(input logic [31:0] pc);
    longint unsigned a;
    a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 64'h4000);
  endfunction

  function automatic npc_sel_e model_sel(input bit st, br, exc, eret);
    if (exc)               return SEL_EXC;
    if (eret)              return SEL_ERET;
    if (st)                return SEL_HOLD;
    if (br)                return SEL_BR;
    if (m_q.size() != 0)   return SEL_PEND;
    return SEL_SEQ;
  endfunction

  function automatic logic [31:0] model_next(input bit st, br, input logic [31:0] tgt,
                                             input bit exc, eret, input logic [31:0] epc);
    case (model_sel(st, br, exc, eret))
      SEL_EXC:  return 32'h0000_4180;
      SEL_ERET: return epc;
      SEL_HOLD: return m_pc;
      SEL_BR:   return tgt;
      SEL_PEND: return m_q[0];
      default:  return m_pc + 32'd4;
    endcase
  endfunction

  task automatic cycle(input bit rst, st, br, input logic [31:0] tgt,
                       input bit exc, eret, input logic [31:0] epc);
    logic [31:0] nxt;
    @(negedge clk);
    reset = rst; stall_i = st; br_take_i = br; br_target_i = tgt;
    exc_req_i = exc; eret_i = eret; epc_i = epc;
    #1;
    if (m_valid) begin
      nxt = model_next(st, br, tgt, exc, eret, epc);
      check("pc", pc_o, m_pc);
      check("pend", 32'(redir_pend_o), 32'(m_q.size() != 0));
      check("adel", 32'(fetch_adel_o), 32'(ref_adel(m_pc)));
      check("npc", npc_o, nxt);
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0000_3000;
      m_q.delete();
    end else begin
      m_pc = model_next(st, br, tgt, exc, eret, epc);
      if (!exc && !eret && st) begin
        if (br) begin
          m_q.delete();
          m_q.push_back(tgt);
        end
      end else begin
        m_q.delete();
      end
    end
    m_valid = 1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic expect_now(input string tag, input logic [31:0] pc, input bit pend, input bit adel);
    #1;
    check({tag, "_pc"}, pc_o, pc);
    check({tag, "_pend"}, 32'(redir_pend_o), 32'(pend));
    check({tag, "_adel"}, 32'(fetch_adel_o), 32'(adel));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tgt;
    bit rst, st, br, exc, eret;

    // Reset and sequential fetch
    cycle(1, 0, 0, 32'h0, 0, 0, 32'h0);
    expect_now("rst", 32'h3000, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      idle();
      expect_now("seq", 32'h3000 + 32'(4 * i), 0, 0);
    end

    // Branch captured during a three-cycle stall
    cycle(0, 1, 1, 32'h3100, 0, 0, 32'h0);
    expect_now("stall1", 32'h3010, 1, 0);
    cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
    expect_now("stall3", 32'h3010, 1, 0);
    idle();
    expect_now("unstall", 32'h3100, 0, 0);

    // Newer buffered target overwrites older; fresh branch beats pending
    cycle(0, 1, 1, 32'h3100, 0, 0, 32'h0);
    cycle(0, 1, 1, 32'h3200, 0, 0, 32'h0);
    idle();
    expect_now("overwrite", 32'h3200, 0, 0);
    cycle(0, 1, 1, 32'h3200, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h3300, 0, 0, 32'h0);
    expect_now("newbr", 32'h3300, 0, 0);

    // Exception beats ERET and stall, then ERET returns
    cycle(0, 1, 1, 32'h3400, 0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0, 1, 1, 32'h3008);
    expect_now("exc", 32'h4180, 0, 0);
    cycle(0, 0, 0, 32'h0, 0, 1, 32'h3008);
    expect_now("eret", 32'h3008, 0, 0);

    // Fetch window boundaries
    cycle(0, 0, 1, 32'h3002, 0, 0, 32'h0);
    expect_now("mis", 32'h3002, 0, 1);
    cycle(0, 0, 1, 32'h2FFC, 0, 0, 32'h0);
    expect_now("below", 32'h2FFC, 0, 1);
    cycle(0, 0, 1, 32'h6FFC, 0, 0, 32'h0);
    expect_now("last", 32'h6FFC, 0, 0);
    cycle(0, 0, 1, 32'h7000, 0, 0, 32'h0);
    expect_now("above", 32'h7000, 0, 1);

    // Wraparound, then reset while stalled with a pending redirect
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    idle();
    expect_now("wrap", 32'h0000_0000, 0, 1);
    cycle(0, 1, 1, 32'h3500, 0, 0, 32'h0);
    cycle(1, 1, 0, 32'h0, 0, 0, 32'h0);
    expect_now("rst_pend", 32'h3000, 0, 0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 99) < 2);
      st   = ($urandom_range(0, 99) < 40);
      br   = ($urandom_range(0, 99) < 30);
      exc  = ($urandom_range(0, 99) < 5);
      eret = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) tgt = $urandom();
      else tgt = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
      cycle(rst, st, br, tgt, exc, eret, 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
